// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared opcodes, state encoding and width default for muldiv_unit
//
// Purpose: constants shared by the multiply/divide unit and its users.
//   N_DEFAULT   default datapath width
//   F3_*        RV32M funct3 encodings
//   state_t     IDLE/RUN/FIX/DONE control states
package muldiv_pkg;

  localparam int N_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with register write-back
//
// Purpose: computes one M-extension operation over N+2 cycles (1 cycle for
// divide-by-zero and signed overflow) and presents a register write-back.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           request, sampled only while idle
//   funct3          operation select (MUL..REMU)
//   op_a, op_b      rs1 / rs2 operands
//   rd_in           destination register index
//   busy            operation in flight (through the done cycle)
//   done            one-cycle result-valid pulse
//   wb_we           register write enable (done and wb_reg != 0)
//   wb_reg          latched destination index
//   wb_data         result, held until the next done
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic [4:0]   rd_in,
  output logic         busy,
  output logic         done,
  output logic         wb_we,
  output logic [4:0]   wb_reg,
  output logic [N-1:0] wb_data
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      f3_q;
  logic            sa_q, sb_q;
  logic [N-1:0]    mb_q;
  logic [2*N-1:0]  acc_q;   // multiply: {partial high, multiplier}; divide: {remainder, quotient}
  logic [4:0]      rd_q;
  logic            busy_q, done_q, we_q;
  logic [N-1:0]    data_q;

  // Operand classification at request time
  logic            is_div, a_signed, b_signed, b_zero, ovf, special;
  logic [N-1:0]    ma, mb, special_res;

  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) || (is_div && !funct3[0]);
    b_signed = (funct3 == F3_MULH) || (is_div && !funct3[0]);
    ma       = (a_signed && op_a[N-1]) ? (~op_a + 1'b1) : op_a;
    mb       = (b_signed && op_b[N-1]) ? (~op_b + 1'b1) : op_b;
    b_zero   = (op_b == '0);
    ovf      = is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    special  = is_div && (b_zero || ovf);
    // funct3[1] selects remainder among the divide ops
    if (b_zero) special_res = funct3[1] ? op_a : '1;
    else        special_res = funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration of each datapath
  logic [N:0]     mul_sum, rem_sh, div_diff;
  logic [2*N-1:0] acc_mul, acc_div;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mb_q} : '0);
    acc_mul  = {mul_sum, acc_q[N-1:1]};
    // Remainder shifted left with the next dividend bit; N+1 bits keep the carry-out
    rem_sh   = acc_q[2*N-1:N-1];
    div_diff = rem_sh - {1'b0, mb_q};
    acc_div  = div_diff[N] ? {rem_sh[N-1:0], acc_q[N-2:0], 1'b0}
                           : {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
  end

  // Sign fix-up and result select
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? (~acc_q[N-1:0] + 1'b1) : acc_q[N-1:0];
    rem_fix  = sa_q ? (~acc_q[2*N-1:N] + 1'b1) : acc_q[2*N-1:N];
    case (f3_q)
      F3_MUL:                     fix_res = prod_fix[N-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*N-1:N];
      F3_DIV, F3_DIVU:            fix_res = quo_fix;
      default:                    fix_res = rem_fix;
    endcase
  end

  // Control FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = special ? S_DONE : S_RUN;
      S_RUN:  if (cnt_q == CW'(N-1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      f3_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      mb_q   <= '0;
      acc_q  <= '0;
      rd_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      we_q   <= 1'b0;
      data_q <= '0;
    end else begin
      // Outputs lag the state by one cycle, so done lands N+2 edges after start
      busy_q <= (state_d != S_IDLE) || (state_q == S_DONE);
      done_q <= (state_q == S_DONE);
      we_q   <= (state_q == S_DONE) && (rd_q != 5'd0);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            f3_q  <= funct3;
            rd_q  <= rd_in;
            sa_q  <= a_signed && op_a[N-1];
            sb_q  <= b_signed && op_b[N-1];
            mb_q  <= mb;
            acc_q <= {{N{1'b0}}, ma};
            cnt_q <= '0;
            if (special) data_q <= special_res;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= f3_q[2] ? acc_div : acc_mul;
        end
        S_FIX:   data_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wb_we   = we_q;
  assign wb_reg  = rd_q;
  assign wb_data = data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.N(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    logic [63:0] p;
    logic ov;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f3)
      F3_MUL:    begin p = ua * ub; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; if (ov) return 32'h8000_0000; p = sa / sb; return p[31:0]; end
      F3_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      F3_REM:    begin if (b == 0) return a; if (ov) return 32'd0; p = sa % sb; return p[31:0]; end
      default:   begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  // Issue one op from an idle cycle (#1 after a posedge) and wait for done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output logic [31:0] d, output logic we, output logic [4:0] r,
                        output int lat, output int busy_low, output logic post_idle);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
    lat = 0; busy_low = busy ? 0 : 1;
    d = '0; we = 1'b0; r = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (!busy) busy_low++;
      if (done) break;
    end
    d = wb_data; we = wb_we; r = wb_reg;
    @(posedge clk); #1;
    post_idle = !busy && !done && !wb_we;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] exp_d;
    logic        exp_we;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] d;
    logic we, pi;
    logic [4:0] r;
    int lat, bl, ndone;

    vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b1, 34};
    vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1'b1, 34};
    vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 1'b1, 34};
    vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF, 1'b1, 34};
    vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 1'b1, 34};
    vecs[5]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 1'b1, 34};
    vecs[6]  = '{F3_DIVU,   32'd100,        32'd7,         5'd7,  32'd14,        1'b1, 34};
    vecs[7]  = '{F3_REMU,   32'd100,        32'd7,         5'd8,  32'd2,         1'b1, 34};
    vecs[8]  = '{F3_DIVU,   32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1'b1, 1};
    vecs[9]  = '{F3_REMU,   32'd5,          32'd0,         5'd10, 32'd5,         1'b1, 1};
    vecs[10] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1, 1};
    vecs[11] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1'b1, 1};
    vecs[12] = '{F3_MUL,    32'd3,          32'd4,         5'd0,  32'd12,        1'b0, 34};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_we", 64'(wb_we), 64'd0);
    chk("reset_reg", 64'(wb_reg), 64'd0);
    chk("reset_data", 64'(wb_data), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, d, we, r, lat, bl, pi);
      chk($sformatf("vec%0d_data", i), 64'(d), 64'(vecs[i].exp_d));
      chk($sformatf("vec%0d_we", i), 64'(we), 64'(vecs[i].exp_we));
      chk($sformatf("vec%0d_reg", i), 64'(r), 64'(vecs[i].rd));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_busy", i), 64'(bl), 64'd0);
      chk($sformatf("vec%0d_idle", i), 64'(pi), 64'd1);
    end

    // Randomized against the model, biased towards the division corner cases
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      logic [31:0] a, b;
      logic [4:0] rd;
      int mode;
      f3 = 3'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
      mode = $urandom_range(0, 9);
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
      else if (mode == 3) b = 32'($urandom_range(0, 3)) - 32'd2;
      run_op(f3, a, b, rd, d, we, r, lat, bl, pi);
      chk($sformatf("rnd%0d_data f3=%0d a=%h b=%h", i, f3, a, b), 64'(d), 64'(ref_res(f3, a, b)));
      chk($sformatf("rnd%0d_we", i), 64'(we), 64'(rd != 0));
      chk($sformatf("rnd%0d_reg", i), 64'(r), 64'(rd));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(ref_lat(f3, a, b)));
    end

    // Start pulsed mid-RUN is ignored and not queued
    start = 1'b1; funct3 = F3_MUL; op_a = 32'd7; op_b = 32'hFFFF_FFFD; rd_in = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 6;
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      @(posedge clk); #1;
      lat++;
    end
    chk("midrun_lat", 64'(lat), 64'd34);
    chk("midrun_data", 64'(wb_data), 64'hFFFF_FFEB);
    chk("midrun_reg", 64'(wb_reg), 64'd5);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrun_no_queue", 64'(ndone), 64'd0);

    // Reset asserted at cycle 10 of an operation
    start = 1'b1; funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_we", 64'(wb_we), 64'd0);
    chk("abort_data", 64'(wb_data), 64'd0);
    chk("abort_reg", 64'(wb_reg), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run_op(F3_REMU, 32'd100, 32'd7, 5'd4, d, we, r, lat, bl, pi);
    chk("after_abort_data", 64'(d), 64'd2);
    chk("after_abort_lat", 64'(lat), 64'd34);
    chk("after_abort_we", 64'(we), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit for the FemtoRV32 datapath. Takes the two source operands read from `RegisterFile` (RD1/RD2), computes one of the eight M-extension operations over multiple cycles, and presents a write-back triple (`wb_we`, `wb_reg`, `wb_data`) that drives `RegisterFile` WR/WReg/WDATA directly. The core control stalls on `busy` while an operation is in flight.

## Interface
- `N`, default 32, datapath width (operands, result); the iteration count equals `N`.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only in IDLE.
- `funct3`  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  input  N  rs1 value (RD1).
- `op_b`  input  N  rs2 value (RD2).
- `rd_in`  input  5  destination register index.
- `busy`  output  1  high from the cycle after a start is accepted through the DONE cycle.
- `done`  output  1  one-cycle pulse: result valid.
- `wb_we`  output  1  register write enable; equals `done` AND (`wb_reg` != 0).
- `wb_reg`  output  5  latched `rd_in`.
- `wb_data`  output  N  result; holds its value until the next `done`.

## Operation
- States: IDLE, RUN, FIX, DONE. Reset: state IDLE; `busy`, `done`, `wb_we` = 0; `wb_reg` = 0; `wb_data` = 0; counter and accumulators = 0.
- IDLE: on `start`=1, latch `funct3`, `op_a`, `op_b`, `rd_in`. Record operand signs per op: MULH and DIV/REM signed on both; MULHSU signed on `op_a` only; all others unsigned. Store magnitudes (absolute value of signed operands). Go to RUN, or to DONE for special cases.
- Special cases (division only, decided in IDLE, skip RUN/FIX): divisor 0 -> quotient all-ones, remainder = `op_a`. Signed overflow (DIV/REM, `op_a` = 0x80000000, `op_b` = 0xFFFFFFFF) -> quotient 0x80000000, remainder 0.
- RUN: N iterations, one per cycle, counter 0..N-1. Multiply: radix-2 shift-add into a 2N-bit product. Divide: restoring shift-subtract, producing an N-bit quotient and remainder. After iteration N-1, go to FIX.
- FIX: apply sign. Product negated when the operand signs differ (the two's complement of the full 2N bits). Quotient negated when the signs differ; remainder takes the sign of the dividend. Select the output: MUL low N bits; MULH/MULHSU/MULHU high N bits; DIV/DIVU quotient; REM/REMU remainder. Register it into `wb_data`. Go to DONE.
- DONE: `done`=1 and `busy`=1 for exactly one cycle; `wb_we` as defined. Then go to IDLE.
- `start` outside IDLE is ignored and is not queued.
- Reset asserted mid-operation: immediately return to IDLE with all outputs at their reset values. No `done` is produced for the aborted operation.
- `rd_in` = 0: the operation executes and `done` pulses, but `wb_we` stays 0.

## Timing
- Start is accepted at rising edge k. Normal ops: RUN occupies the cycles after edges k+1..k+N, FIX follows edge k+N+1, and `done`/`wb_we` are high in the cycle after edge k+N+2. The latency is N+2 cycles (34 for N=32).
- Special-case division: `done` is high in the cycle after edge k+1 (latency 1).
- Operands and `funct3` may change freely after edge k.
- `busy` rises in the cycle after edge k and falls in the cycle after DONE. A new `start` can be accepted at the edge that ends DONE+1 (IDLE).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `muldiv_pkg`: funct3 opcode localparams (`F3_MUL`…`F3_REMU`), the state encoding for IDLE/RUN/FIX/DONE, and the `N` default.
- Single flat module. The multiply and divide datapaths share the 2N-bit shift register and the counter. No sub-module is required.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), `rd_in`=5 -> `wb_data`=0xFFFFFFEB, `wb_we`=1, `wb_reg`=5, `done` exactly 34 cycles after the start edge; `busy` high throughout.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH on the same operands -> 0x00000000; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with `done` one cycle after start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM of the same -> 0.
- Pulse `start` again mid-RUN with different operands -> ignored, the first result is unchanged. Then pull `rst` low at cycle 10 of an operation -> `busy`/`done`/`wb_we` are 0 immediately, no `done` follows, and the next start works normally.
- MUL 3×4 with `rd_in`=0 -> `done` pulses, `wb_data`=12, `wb_we` stays 0.
